// File: rtl/iot_event_sched.sv
// Round-robin serialiser of per-device connect/disconnect events into a
// single change/on_off strobe, with per-device active flags and a count.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   hold            : suppress new grants while high
//   req, dir        : per-device request and event type (1 = connect)
//   ack, dropped    : one-hot grant pulse, redundant-event flag
//   change, on_off  : single-event strobe and direction to the monitor
//   active_map/cnt  : registered active flags and their popcount
module iot_event_sched #(
  parameter int N_DEV = 4,
  parameter int CNT_W = $clog2(N_DEV + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic [N_DEV-1:0] req,
  input  logic [N_DEV-1:0] dir,
  output logic [N_DEV-1:0] ack,
  output logic             dropped,
  output logic             change,
  output logic             on_off,
  output logic [N_DEV-1:0] active_map,
  output logic [CNT_W-1:0] active_cnt
);

  localparam int PTR_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

  typedef enum logic {S_ARB, S_WAIT} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [N_DEV-1:0]   ack_q, ack_d;
  logic               dropped_q, dropped_d;
  logic               change_q, change_d;
  logic               on_off_q, on_off_d;
  logic [N_DEV-1:0]   map_q, map_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               found;
  logic [PTR_W-1:0]   cand;
  logic [PTR_W-1:0]   gnt_idx;
  logic               grant;

  // Rotating search starting at ptr; first hit wins.
  always_comb begin
    found   = 1'b0;
    cand    = '0;
    gnt_idx = '0;
    for (int k = 0; k < N_DEV; k++) begin
      cand = PTR_W'((32'(ptr_q) + 32'(k)) % N_DEV);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  assign grant = (state_q == S_ARB) && !hold && found;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_ARB;
      ptr_q     <= '0;
      ack_q     <= '0;
      dropped_q <= 1'b0;
      change_q  <= 1'b0;
      on_off_q  <= 1'b0;
      map_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      ack_q     <= ack_d;
      dropped_q <= dropped_d;
      change_q  <= change_d;
      on_off_q  <= on_off_d;
      map_q     <= map_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_ARB:  if (grant) state_d = S_WAIT;
      S_WAIT: state_d = S_ARB;
      default: state_d = S_ARB;
    endcase
  end

  // Output / datapath next values; strobes default low so they last
  // exactly the WAIT cycle.
  always_comb begin
    ptr_d     = ptr_q;
    ack_d     = '0;
    dropped_d = 1'b0;
    change_d  = 1'b0;
    on_off_d  = 1'b0;
    map_d     = map_q;
    if (grant) begin
      ack_d[gnt_idx] = 1'b1;
      ptr_d = PTR_W'((32'(gnt_idx) + 32'd1) % N_DEV);
      if (dir[gnt_idx] != map_q[gnt_idx]) begin
        change_d        = 1'b1;
        on_off_d        = dir[gnt_idx];
        map_d[gnt_idx]  = dir[gnt_idx];
      end else begin
        dropped_d = 1'b1;
      end
    end
    // Count from the next-state map so it moves on the same edge as change.
    cnt_d = '0;
    for (int k = 0; k < N_DEV; k++) begin
      cnt_d = cnt_d + CNT_W'(map_d[k]);
    end
  end

  assign ack        = ack_q;
  assign dropped    = dropped_q;
  assign change     = change_q;
  assign on_off     = on_off_q;
  assign active_map = map_q;
  assign active_cnt = cnt_q;

endmodule

// File: tb/tb_iot_event_sched.sv
// Bench for iot_event_sched: directed scenarios plus random requesters,
// expected outputs queued by a reference model and checked by a monitor.
module tb_iot_event_sched;

  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  typedef struct packed {
    logic [N-1:0]  ack;
    logic          dropped;
    logic          change;
    logic          on_off;
    logic [N-1:0]  map;
    logic [CW-1:0] cnt;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          hold;
  logic [N-1:0]  req;
  logic [N-1:0]  dir;
  logic [N-1:0]  ack;
  logic          dropped;
  logic          change;
  logic          on_off;
  logic [N-1:0]  active_map;
  logic [CW-1:0] active_cnt;

  iot_event_sched #(.N_DEV(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .req        (req),
    .dir        (dir),
    .ack        (ack),
    .dropped    (dropped),
    .change     (change),
    .on_off     (on_off),
    .active_map (active_map),
    .active_cnt (active_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: device activity, rotation start, busy cycle.
  bit [N-1:0] m_act  = '0;
  int         m_ptr  = 0;
  bit         m_busy = 1'b0;
  int         m_gnt  = -1;

  task automatic cycle(input bit r, input bit h,
                       input bit [N-1:0] rq, input bit [N-1:0] dr);
    exp_t e;
    rst  = r;
    hold = h;
    req  = rq;
    dir  = dr;
    e     = '0;
    m_gnt = -1;
    if (r) begin
      m_act  = '0;
      m_ptr  = 0;
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_busy = 1'b0;
    end else if (!h && rq != '0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr + k) % N;
        if (m_gnt < 0 && rq[c]) m_gnt = c;
      end
      e.ack[m_gnt] = 1'b1;
      m_ptr  = (m_gnt + 1) % N;
      m_busy = 1'b1;
      if (dr[m_gnt] != m_act[m_gnt]) begin
        e.change      = 1'b1;
        e.on_off      = dr[m_gnt];
        m_act[m_gnt]  = dr[m_gnt];
      end else begin
        e.dropped = 1'b1;
      end
    end
    e.map = m_act;
    e.cnt = CW'($countones(m_act));
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: each negedge shows the result of the preceding edge.
  initial begin
    exp_t e;
    exp_t a;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{ack, dropped, change, on_off, active_map, active_cnt};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t: ack=%b drop=%b chg=%b onoff=%b map=%b cnt=%0d, required ack=%b drop=%b chg=%b onoff=%b map=%b cnt=%0d",
                   $time, a.ack, a.dropped, a.change, a.on_off, a.map, a.cnt,
                   e.ack, e.dropped, e.change, e.on_off, e.map, e.cnt);
        end
      end
    end
  end

  initial begin
    bit [N-1:0] pend;
    bit [N-1:0] pdir;
    bit         r;
    bit         h;
    pend = '0;
    pdir = '0;

    // Reset then idle.
    repeat (2) cycle(1, 0, 4'b0000, 4'b0000);
    repeat (5) cycle(0, 0, 4'b0000, 4'b0000);

    // Connect device 0, then a redundant repeat.
    cycle(0, 0, 4'b0001, 4'b0001);
    cycle(0, 0, 4'b0000, 4'b0001);
    cycle(0, 0, 4'b0001, 4'b0001);
    cycle(0, 0, 4'b0000, 4'b0001);

    // All four connect, then all disconnect, from ptr=0.
    cycle(1, 0, 4'b0000, 4'b0000);
    repeat (8) cycle(0, 0, 4'b1111, 4'b1111);
    repeat (8) cycle(0, 0, 4'b1111, 4'b0000);

    // Wrap-around: grant 3, then 1001 must go to device 0.
    cycle(0, 0, 4'b1000, 4'b1000);
    cycle(0, 0, 4'b0000, 4'b1000);
    cycle(0, 0, 4'b1001, 4'b1001);
    cycle(0, 0, 4'b1000, 4'b1000);
    cycle(0, 0, 4'b1000, 4'b1000);
    cycle(0, 0, 4'b0000, 4'b0000);

    // Hold blocks grants; release grants one cycle later.
    repeat (6) cycle(0, 1, 4'b0010, 4'b0000);
    cycle(0, 0, 4'b0010, 4'b0000);
    cycle(0, 1, 4'b0000, 4'b0000);
    cycle(0, 0, 4'b0000, 4'b0000);

    // Reset during the WAIT cycle.
    cycle(0, 0, 4'b0100, 4'b0100);
    cycle(1, 0, 4'b0000, 4'b0000);
    cycle(0, 0, 4'b0011, 4'b0011);
    cycle(0, 0, 4'b0000, 4'b0011);

    // Random requesters obeying the handshake.
    for (int i = 0; i < 1500; i++) begin
      for (int d = 0; d < N; d++) begin
        if (!pend[d] && $urandom_range(0, 3) == 0) begin
          pend[d] = 1'b1;
          pdir[d] = 1'($urandom_range(0, 1));
        end else if (pend[d] && $urandom_range(0, 40) == 0) begin
          pend[d] = 1'b0;
        end
      end
      h = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 149) == 0);
      cycle(r, h, pend, pdir);
      if (m_gnt >= 0) pend[m_gnt] = 1'b0;
    end

    cycle(0, 0, 4'b0000, 4'b0000);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iot_event_sched.md
Name: iot_event_sched

Overview:
- Round-robin scheduler that serialises connect/disconnect events from N_DEV IoT device ports into the single-event interface (change, on_off) of the active-device monitor counter.
- Tracks each device's active state, drops redundant events, and reports the resulting active-device count for cross-checking against the monitor.
- Sits between the device-side requesters and the monitor, in the same clk domain.

Parameters:
- N_DEV, 4, number of device requesters (≥2).
- CNT_W, $clog2(N_DEV+1), width of active_cnt.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- hold  in  1  1 = issue no new grants; pending requests wait.
- req  in  N_DEV  per-device event request; held high until ack.
- dir  in  N_DEV  per-device event type: 1 = connect, 0 = disconnect; stable while req high.
- ack  out  N_DEV  one-hot grant/acknowledge pulse, 1 cycle.
- dropped  out  1  pulses with ack when the granted event was redundant.
- change  out  1  to monitor: 1-cycle event strobe.
- on_off  out  1  to monitor: direction of event (1 = up/connect).
- active_map  out  N_DEV  registered per-device active flags.
- active_cnt  out  CNT_W  registered popcount of active_map.

Behaviour:
- Interface fixed: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - state=ARB, ptr=0.
  - ack, dropped, change, on_off, active_map, active_cnt all 0.
  - Applies mid-operation: any in-flight ack/change is cleared at that edge; the event is lost and the requester must re-request.
- FSM has two states, ARB and WAIT. Maximum throughput is one event per 2 cycles.
- ARB state:
  - If hold=0 and req≠0: pick index i = the first set req bit searching ptr, ptr+1, …, N_DEV-1, 0, …, ptr-1.
  - At the next edge:
    - ack[i]=1.
    - ptr=(i+1) mod N_DEV.
    - state=WAIT.
    - If dir[i]≠active_map[i]: change=1, on_off=dir[i], dropped=0, active_map[i]=dir[i].
    - Else: change=0, on_off=0, dropped=1, active_map unchanged.
  - If hold=1 or req=0: stay in ARB; all strobes are 0.
- WAIT state:
  - ack/change/dropped are visible for exactly this cycle.
  - Next edge: all strobes return to 0, state=ARB.
  - No arbitration happens in WAIT; the requester must drop or refresh req at the edge after it sees ack.
- Request-to-ack latency: 1 cycle when uncontended; worst case 2·(N_DEV-1)+1 cycles.
- active_cnt:
  - Registered from the next-state active_map, so it updates on the same edge as change.
  - Never exceeds N_DEV and never underflows, because redundant events are dropped.
- hold:
  - Sampled only in ARB.
  - Asserting hold during WAIT does not cancel the current ack.
- Misuse: req deasserted before ack is permitted; the request is simply withdrawn and nothing is recorded.
- Only one bit of ack is ever high at a time. change and dropped are never both high.

Test Plan:
1. rst=1 for 2 cycles, then req=0 for 5 cycles -> all outputs 0, active_cnt=0.
2. req=4'b0001, dir=4'b0001 -> next cycle ack=0001, change=1, on_off=1; active_map=0001, active_cnt=1. A repeat connect from device 0 -> ack=0001, dropped=1, change=0, active_cnt stays 1.
3. req=4'b1111 held continuously, dir=4'b1111, ptr=0 -> acks 0001, 0010, 0100, 1000 on cycles 1, 3, 5, 7; change pulses 4 times; active_cnt=4. Then all disconnect -> active_cnt steps down 3, 2, 1, 0.
4. After ack of device 3, req=4'b1001 -> device 0 is granted next (wrap-around); device 3 is not granted back-to-back.
5. hold=1 with req=4'b0010 for 6 cycles -> ack=0 throughout. Release hold -> ack=0010 one cycle later.
6. rst=1 asserted in the WAIT cycle -> ack and change are 0 at the following edge, active_map=0, ptr=0.
